// File: rtl/issue_ctrl.sv
// Issue and hazard controller: scoreboard of pending register writes, RAW/WAW
// stall and bubble generation, in-flight write cap and HALT drain sequencing.
module issue_ctrl #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [15:0] inst,
    input  logic        wer,
    input  logic [3:0]  rdestrr,
    input  logic        resume,
    output logic        issue,
    output logic        stall,
    output logic        pc_en,
    output logic        bubble,
    output logic [15:0] busy,
    output logic [3:0]  inflight,
    output logic        halted
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]  state_r, state_nxt_s;
    logic [15:0] busy_r, busy_nxt_s;
    logic [3:0]  inflight_r;
    logic        halted_r;
    logic [15:0] src_mask_s, dst_mask_s;
    logic        has_dst_s, is_halt_s, hazard_s, full_s;
    logic        issue_s, stall_s, pc_en_s;

    function automatic logic [15:0] onehot16(input logic [3:0] r);
        return 16'h0001 << r;
    endfunction

    // Popcount wraps at 16, but the in-flight cap keeps the true count <= 15.
    function automatic logic [3:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c[3:0];
    endfunction

    // Decode source/destination register masks from the opcode class.
    always_comb begin
        src_mask_s = 16'h0000;
        dst_mask_s = 16'h0000;
        is_halt_s  = 1'b0;
        case (inst[15:12])
            4'h0: begin
                if (inst != 16'h0000) begin
                    src_mask_s = onehot16(inst[11:8]) | onehot16(inst[7:4]);
                    dst_mask_s = onehot16(inst[11:8]);
                end else begin
                    src_mask_s = 16'h0000;
                    dst_mask_s = 16'h0000;
                end
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                src_mask_s = onehot16(inst[11:8]) | onehot16(inst[7:4]);
                dst_mask_s = onehot16(inst[11:8]);
            end
            4'h8, 4'h9, 4'hA, 4'hB: begin
                src_mask_s = onehot16(inst[11:8]);
                dst_mask_s = onehot16(inst[11:8]);
            end
            4'hC: dst_mask_s = onehot16(inst[11:8]);
            4'hD, 4'hE: src_mask_s = onehot16(inst[11:8]) | onehot16(inst[7:4]);
            4'hF: is_halt_s = 1'b1;
            default: begin
                src_mask_s = 16'h0000;
                dst_mask_s = 16'h0000;
                is_halt_s  = 1'b0;
            end
        endcase
    end

    assign has_dst_s = |dst_mask_s;
    assign hazard_s  = |((src_mask_s | dst_mask_s) & busy_r);
    assign full_s    = has_dst_s && (inflight_r == MAX_INFLIGHT[3:0]);

    // Issue/stall decision; all handshake outputs held low while in reset.
    always_comb begin
        issue_s = 1'b0;
        stall_s = 1'b0;
        pc_en_s = 1'b0;
        if (!rst) begin
            issue_s = 1'b0;
            stall_s = 1'b0;
            pc_en_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    issue_s = inst_valid & ~hazard_s & ~full_s;
                    stall_s = inst_valid & ~issue_s;
                    pc_en_s = ~stall_s;
                end
                ST_DRAIN, ST_HALTED: begin
                    issue_s = 1'b0;
                    stall_s = 1'b1;
                    pc_en_s = 1'b0;
                end
                default: begin
                    issue_s = 1'b0;
                    stall_s = 1'b1;
                    pc_en_s = 1'b0;
                end
            endcase
        end
    end

    // Scoreboard next value: set on dst issue, clear on writeback (no bypass).
    always_comb begin
        busy_nxt_s = busy_r;
        if (issue_s && has_dst_s) begin
            busy_nxt_s = busy_nxt_s | dst_mask_s;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (wer) begin
            busy_nxt_s = busy_nxt_s & ~onehot16(rdestrr);
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Run/drain/halt sequencing; drain ends on the edge the scoreboard empties.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (issue_s && is_halt_s) state_nxt_s = ST_DRAIN;
                else                      state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (busy_nxt_s == 16'h0000) state_nxt_s = ST_HALTED;
                else                        state_nxt_s = ST_DRAIN;
            end
            ST_HALTED: begin
                if (resume) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_HALTED;
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State, scoreboard and derived registered status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_RUN;
            busy_r     <= 16'h0000;
            inflight_r <= 4'd0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= busy_nxt_s;
            inflight_r <= popcount16(busy_nxt_s);
            halted_r   <= (state_nxt_s == ST_HALTED);
        end
    end

    assign issue    = issue_s;
    assign stall    = stall_s;
    assign pc_en    = pc_en_s;
    assign bubble   = stall_s;
    assign busy     = busy_r;
    assign inflight = inflight_r;
    assign halted   = halted_r;

endmodule
